// File: rtl/lagd_pkg.sv
// Shared types and helpers for the LAGD register-bus broadcast demultiplexer.
package lagd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    UNICAST = 2'd1,
    BCAST   = 2'd2,
    RESP    = 2'd3
  } reg_demux_state_e;

  // Default register-bus flavour: 48-bit address, 32-bit data.
  typedef struct packed {
    logic [47:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } lagd_reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } lagd_reg_rsp_t;

  // The broadcast window sits directly above the last target window.
  function automatic int unsigned bcast_idx(input int unsigned num_targets);
    return num_targets;
  endfunction

  function automatic int unsigned idx_width(input int unsigned num_targets);
    return (num_targets > 0) ? $clog2(num_targets + 1) : 1;
  endfunction

endpackage

// File: rtl/lagd_reg_demux_decode.sv
// Combinational address-window decode: unicast index, broadcast window, or error.
module lagd_reg_demux_decode
  import lagd_pkg::*;
#(
  parameter int unsigned          NumTargets     = 4,
  parameter int unsigned          AddrWidth      = 48,
  parameter logic [AddrWidth-1:0] BaseAddr       = '0,
  parameter int unsigned          TargetSpanLog2 = 16,
  localparam int unsigned         IdxW           = idx_width(NumTargets)
) (
  input  logic [AddrWidth-1:0] addr_i,
  input  logic                 write_i,
  output logic [AddrWidth-1:0] off_o,
  output logic [IdxW-1:0]      idx_o,
  output logic                 is_bcast_o,
  output logic                 dec_err_o
);

  logic [AddrWidth-1:0] off;
  logic [AddrWidth-1:0] win;
  logic                 below;
  logic                 is_uni;
  logic                 is_bwin;

  assign off   = addr_i - BaseAddr;
  assign win   = off >> TargetSpanLog2;
  // Addresses under the base wrap around in the subtraction, so reject them explicitly.
  assign below = addr_i < BaseAddr;

  assign is_uni     = !below && (win < AddrWidth'(NumTargets));
  assign is_bwin    = !below && (win == AddrWidth'(bcast_idx(NumTargets)));
  assign is_bcast_o = is_bwin && write_i;
  assign dec_err_o  = !is_uni && !is_bcast_o;
  assign idx_o      = win[IdxW-1:0];
  assign off_o      = off;

endmodule

// File: rtl/lagd_reg_bcast_demux.sv
// Register-bus fan-out to NumTargets slaves with unicast windows, a broadcast-write window and a timeout.
module lagd_reg_bcast_demux
  import lagd_pkg::*;
#(
  parameter int unsigned          NumTargets     = 4,
  parameter int unsigned          AddrWidth      = 48,
  parameter int unsigned          DataWidth      = 32,
  parameter logic [AddrWidth-1:0] BaseAddr       = '0,
  parameter int unsigned          TargetSpanLog2 = 16,
  parameter int unsigned          TimeoutCycles  = 255,
  parameter type                  reg_req_t      = lagd_reg_req_t,
  parameter type                  reg_rsp_t      = lagd_reg_rsp_t
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  reg_req_t                   slv_req_i,
  output reg_rsp_t                   slv_rsp_o,
  output reg_req_t [NumTargets-1:0]  mst_req_o,
  input  reg_rsp_t [NumTargets-1:0]  mst_rsp_i,
  output logic                       bcast_busy_o,
  output logic                       timeout_o,
  output logic [15:0]                err_cnt_o,
  output reg_demux_state_e           state_o
);

  // Handshake: upstream valid is sampled only in IDLE; ready is a one-cycle response strobe
  // carrying rdata/error. Downstream valid stays high until that target's ready is seen.

  localparam int unsigned IdxW  = idx_width(NumTargets);
  localparam int unsigned StrbW = DataWidth / 8;
  localparam int unsigned CntW  = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [AddrWidth-1:0] OffMask =
    (AddrWidth'(1) << TargetSpanLog2) - AddrWidth'(1);

  reg_demux_state_e        state_q, state_d;
  logic [AddrWidth-1:0]    addr_q, addr_d;
  logic                    write_q, write_d;
  logic [DataWidth-1:0]    wdata_q, wdata_d;
  logic [StrbW-1:0]        wstrb_q, wstrb_d;
  logic [NumTargets-1:0]   valid_q, valid_d;
  logic [NumTargets-1:0]   done_q, done_d;
  logic                    err_q, err_d;
  logic [DataWidth-1:0]    rdata_q, rdata_d;
  logic                    ready_q, ready_d;
  logic [CntW-1:0]         tcnt_q, tcnt_d;
  logic                    timeout_q, timeout_d;
  logic [15:0]             err_cnt_q, err_cnt_d;

  logic [AddrWidth-1:0]    dec_off;
  logic [IdxW-1:0]         dec_idx;
  logic                    dec_bcast;
  logic                    dec_err;
  logic                    expire;

  lagd_reg_demux_decode #(
    .NumTargets     (NumTargets),
    .AddrWidth      (AddrWidth),
    .BaseAddr       (BaseAddr),
    .TargetSpanLog2 (TargetSpanLog2)
  ) u_decode (
    .addr_i     (slv_req_i.addr),
    .write_i    (slv_req_i.write),
    .off_o      (dec_off),
    .idx_o      (dec_idx),
    .is_bcast_o (dec_bcast),
    .dec_err_o  (dec_err)
  );

  assign expire = (TimeoutCycles != 0) && (tcnt_q == CntW'(TimeoutCycles - 1));

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    valid_d   = valid_q;
    done_d    = done_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    ready_d   = 1'b0;
    tcnt_d    = tcnt_q;
    timeout_d = 1'b0;
    err_cnt_d = err_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (slv_req_i.valid) begin
          addr_d  = dec_off & OffMask;
          write_d = slv_req_i.write;
          wdata_d = slv_req_i.wdata;
          wstrb_d = slv_req_i.wstrb;
          tcnt_d  = '0;
          rdata_d = '0;
          err_d   = 1'b0;
          if (dec_err) begin
            state_d = RESP;
            ready_d = 1'b1;
            err_d   = 1'b1;
          end else if (dec_bcast) begin
            state_d = BCAST;
            valid_d = '1;
            done_d  = '0;
          end else begin
            state_d = UNICAST;
            for (int i = 0; i < NumTargets; i++) begin
              valid_d[i] = (IdxW'(i) == dec_idx);
            end
            // Unicast reuses the broadcast completion test by pre-marking the others done.
            done_d = ~valid_d;
          end
        end
      end
      UNICAST, BCAST: begin
        for (int i = 0; i < NumTargets; i++) begin
          if (valid_q[i] && mst_rsp_i[i].ready) begin
            valid_d[i] = 1'b0;
            done_d[i]  = 1'b1;
            err_d      = err_d | mst_rsp_i[i].error;
            if (state_q == UNICAST) rdata_d = mst_rsp_i[i].rdata;
          end
        end
        if (&done_d) begin
          state_d = RESP;
          ready_d = 1'b1;
        end else if (expire) begin
          state_d   = RESP;
          ready_d   = 1'b1;
          valid_d   = '0;
          err_d     = 1'b1;
          rdata_d   = '0;
          timeout_d = 1'b1;
        end else if (TimeoutCycles != 0) begin
          tcnt_d = tcnt_q + CntW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
        err_d   = 1'b0;
        rdata_d = '0;
        if (err_q && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      valid_q   <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      tcnt_q    <= '0;
      timeout_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      tcnt_q    <= tcnt_d;
      timeout_q <= timeout_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_comb begin
    slv_rsp_o       = '0;
    slv_rsp_o.ready = ready_q;
    slv_rsp_o.error = ready_q & err_q;
    slv_rsp_o.rdata = ready_q ? rdata_q : '0;
    for (int i = 0; i < NumTargets; i++) begin
      mst_req_o[i]       = '0;
      mst_req_o[i].addr  = addr_q;
      mst_req_o[i].write = write_q;
      mst_req_o[i].wdata = wdata_q;
      mst_req_o[i].wstrb = wstrb_q;
      mst_req_o[i].valid = valid_q[i];
    end
  end

  assign bcast_busy_o = (state_q == BCAST);
  assign timeout_o    = timeout_q;
  assign err_cnt_o    = err_cnt_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_lagd_reg_bcast_demux.sv
// Directed bench for lagd_reg_bcast_demux with hand-computed expectations.
module tb_lagd_reg_bcast_demux;
  import lagd_pkg::*;

  localparam int unsigned NT   = 4;
  localparam logic [47:0] BASE = 48'h0000_4000_0000;

  logic                    clk = 1'b0;
  logic                    rst;
  lagd_reg_req_t           slv_req;
  lagd_reg_rsp_t           slv_rsp;
  lagd_reg_req_t [NT-1:0]  mst_req;
  lagd_reg_rsp_t [NT-1:0]  mst_rsp;
  logic                    bcast_busy;
  logic                    timeout;
  logic [15:0]             err_cnt;
  reg_demux_state_e        state;

  int checks = 0;
  int errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  lagd_reg_bcast_demux #(
    .NumTargets     (NT),
    .AddrWidth      (48),
    .DataWidth      (32),
    .BaseAddr       (BASE),
    .TargetSpanLog2 (16),
    .TimeoutCycles  (8)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .slv_req_i    (slv_req),
    .slv_rsp_o    (slv_rsp),
    .mst_req_o    (mst_req),
    .mst_rsp_i    (mst_rsp),
    .bcast_busy_o (bcast_busy),
    .timeout_o    (timeout),
    .err_cnt_o    (err_cnt),
    .state_o      (state)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [47:0] a, input logic w, input logic [31:0] d);
    slv_req.addr  = a;
    slv_req.write = w;
    slv_req.wdata = d;
    slv_req.wstrb = 4'hF;
    slv_req.valid = 1'b1;
  endtask

  task automatic clr_req();
    slv_req.valid = 1'b0;
  endtask

  task automatic clr_rsp();
    mst_rsp = '0;
  endtask

  function automatic logic [NT-1:0] mst_valids();
    logic [NT-1:0] r;
    for (int i = 0; i < NT; i++) r[i] = mst_req[i].valid;
    return r;
  endfunction

  // one decode-error transaction: response in cycle 1, counter visible in cycle 2
  task automatic err_txn(input string tag, input logic [47:0] a, input logic w);
    set_req(a, w, 32'h0);
    tick();
    check_eq({tag, "_ready"}, slv_rsp.ready, 1'b1);
    check_eq({tag, "_error"}, slv_rsp.error, 1'b1);
    check_eq({tag, "_novalid"}, mst_valids(), 4'b0000);
    clr_req();
    tick();
  endtask

  int unsigned rdy_cyc [NT] = '{1, 3, 3, 5};
  logic [NT-1:0] exp_v;

  initial begin
    rst     = 1'b1;
    slv_req = '0;
    mst_rsp = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ready", slv_rsp.ready, 1'b0);
    check_eq("rst_error", slv_rsp.error, 1'b0);
    check_eq("rst_rdata", slv_rsp.rdata, 32'h0);
    check_eq("rst_valid", mst_valids(), 4'b0000);
    check_eq("rst_busy", bcast_busy, 1'b0);
    check_eq("rst_timeout", timeout, 1'b0);
    check_eq("rst_errcnt", err_cnt, 16'h0);
    check_eq("rst_state", state, IDLE);
    #3 rst = 1'b0;
    tick();

    // unicast write to target 2, ready in its first valid cycle
    set_req(BASE + 48'h2_0008, 1'b1, 32'hA5A5_0001);
    tick();
    check_eq("uc_valid", mst_valids(), 4'b0100);
    check_eq("uc_addr", mst_req[2].addr, 48'h8);
    check_eq("uc_wdata", mst_req[2].wdata, 32'hA5A5_0001);
    check_eq("uc_write", mst_req[2].write, 1'b1);
    check_eq("uc_wstrb", mst_req[2].wstrb, 4'hF);
    check_eq("uc_ready_c1", slv_rsp.ready, 1'b0);
    mst_rsp[2].ready = 1'b1;
    tick();
    check_eq("uc_ready_c2", slv_rsp.ready, 1'b1);
    check_eq("uc_error", slv_rsp.error, 1'b0);
    check_eq("uc_valid_drop", mst_valids(), 4'b0000);
    clr_req();
    clr_rsp();
    tick();
    check_eq("uc_ready_c3", slv_rsp.ready, 1'b0);
    check_eq("uc_state_c3", state, IDLE);

    // broadcast write, targets answer in cycles 1,3,3,5, target 1 errors
    set_req(BASE + 48'h4_0000, 1'b1, 32'h1234_5678);
    tick();
    exp_v = 4'b1111;
    for (int c = 1; c <= 5; c++) begin
      check_eq($sformatf("bc_busy_c%0d", c), bcast_busy, 1'b1);
      check_eq($sformatf("bc_valid_c%0d", c), mst_valids(), exp_v);
      check_eq($sformatf("bc_ready_c%0d", c), slv_rsp.ready, 1'b0);
      for (int t = 0; t < NT; t++) begin
        mst_rsp[t].ready = (rdy_cyc[t] == c);
        mst_rsp[t].error = (t == 1);
      end
      tick();
      for (int t = 0; t < NT; t++) if (rdy_cyc[t] == c) exp_v[t] = 1'b0;
    end
    check_eq("bc_ready_c6", slv_rsp.ready, 1'b1);
    check_eq("bc_error_c6", slv_rsp.error, 1'b1);
    check_eq("bc_rdata_c6", slv_rsp.rdata, 32'h0);
    check_eq("bc_busy_c6", bcast_busy, 1'b0);
    check_eq("bc_valid_c6", mst_valids(), 4'b0000);
    clr_req();
    clr_rsp();
    tick();
    check_eq("bc_errcnt", err_cnt, 16'd1);

    // broadcast read, out-of-range window, below base
    err_txn("bcrd", BASE + 48'h4_0000, 1'b0);
    check_eq("bcrd_errcnt", err_cnt, 16'd2);
    err_txn("oor", BASE + 48'h7_0010, 1'b1);
    check_eq("oor_errcnt", err_cnt, 16'd3);
    err_txn("below", BASE - 48'h1, 1'b0);
    check_eq("below_errcnt", err_cnt, 16'd4);

    // timeout: target 0 never answers, expiry in cycle 8
    set_req(BASE + 48'h0_0040, 1'b0, 32'h0);
    tick();
    for (int c = 1; c <= 8; c++) begin
      check_eq($sformatf("to_valid_c%0d", c), mst_valids(), 4'b0001);
      check_eq($sformatf("to_pulse_c%0d", c), timeout, 1'b0);
      tick();
    end
    check_eq("to_pulse_c9", timeout, 1'b1);
    check_eq("to_ready_c9", slv_rsp.ready, 1'b1);
    check_eq("to_error_c9", slv_rsp.error, 1'b1);
    check_eq("to_rdata_c9", slv_rsp.rdata, 32'h0);
    check_eq("to_valid_c9", mst_valids(), 4'b0000);
    clr_req();
    tick();
    check_eq("to_pulse_c10", timeout, 1'b0);
    check_eq("to_ready_c10", slv_rsp.ready, 1'b0);
    check_eq("to_errcnt", err_cnt, 16'd5);

    // ready arrives in the expiry cycle: normal response
    set_req(BASE + 48'h3_0004, 1'b0, 32'h0);
    tick();
    check_eq("rx_addr", mst_req[3].addr, 48'h4);
    repeat (7) tick();
    check_eq("rx_valid_c8", mst_valids(), 4'b1000);
    mst_rsp[3].ready = 1'b1;
    mst_rsp[3].rdata = 32'hDEAD_BEEF;
    tick();
    check_eq("rx_ready_c9", slv_rsp.ready, 1'b1);
    check_eq("rx_error_c9", slv_rsp.error, 1'b0);
    check_eq("rx_rdata_c9", slv_rsp.rdata, 32'hDEAD_BEEF);
    check_eq("rx_pulse_c9", timeout, 1'b0);
    clr_req();
    clr_rsp();
    tick();
    check_eq("rx_errcnt", err_cnt, 16'd5);

    // reset in the middle of a broadcast
    set_req(BASE + 48'h4_0000, 1'b1, 32'hCAFE_0000);
    tick();
    tick();
    check_eq("rb_busy_pre", bcast_busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_eq("rb_valid", mst_valids(), 4'b0000);
    check_eq("rb_busy", bcast_busy, 1'b0);
    check_eq("rb_ready", slv_rsp.ready, 1'b0);
    check_eq("rb_errcnt", err_cnt, 16'h0);
    check_eq("rb_state", state, IDLE);
    clr_req();
    #2 rst = 1'b0;
    tick();
    check_eq("rb_noresp", slv_rsp.ready, 1'b0);
    set_req(BASE + 48'h1_0020, 1'b0, 32'h0);
    tick();
    check_eq("rb_next_valid", mst_valids(), 4'b0010);
    check_eq("rb_next_addr", mst_req[1].addr, 48'h20);
    check_eq("rb_next_write", mst_req[1].write, 1'b0);
    mst_rsp[1].ready = 1'b1;
    mst_rsp[1].rdata = 32'h0BAD_F00D;
    tick();
    check_eq("rb_next_ready", slv_rsp.ready, 1'b1);
    check_eq("rb_next_error", slv_rsp.error, 1'b0);
    check_eq("rb_next_rdata", slv_rsp.rdata, 32'h0BAD_F00D);
    clr_req();
    clr_rsp();
    tick();

    // error counter saturation, starting close to the top
    force dut.err_cnt_q = 16'hFFFA;
    tick();
    release dut.err_cnt_q;
    tick();
    check_eq("sat_preload", err_cnt, 16'hFFFA);
    for (int k = 0; k < 8; k++) begin
      err_txn($sformatf("sat%0d", k), BASE + 48'h9_0000, 1'b1);
      if (k == 2) check_eq("sat_mid", err_cnt, 16'hFFFD);
    end
    check_eq("sat_final", err_cnt, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
